// File: rtl/conv_code_pkg.sv
// conv_code_pkg: shared constants, FSM state type and parity helper for the
// K=7, rate-1/2 convolutional code (encoder and decoder expected-symbol path).
package conv_code_pkg;

   localparam int CONV_K  = 7;
   localparam int MAX_K   = 9;
   localparam int STATE_W = CONV_K - 1;

   localparam logic [CONV_K-1:0] CONV_G0 = 7'o171;
   localparam logic [CONV_K-1:0] CONV_G1 = 7'o133;

   typedef enum logic {RUN, FLUSH} enc_state_t;

   // w and g are MSB-aligned: bit K-1 is the current input, bit 0 the oldest bit.
   function automatic logic parity(input logic [MAX_K-1:0] w,
                                   input logic [MAX_K-1:0] g);
      return ^(w & g);
   endfunction

endpackage

// File: rtl/conv_enc_symbol.sv
// conv_enc_symbol: combinational code-symbol generator for one trellis step.
// sym[0] is the G0 parity, sym[1] the G1 parity of the window {sr, u}.
module conv_enc_symbol
   import conv_code_pkg::*;
#(
   parameter int             K  = CONV_K,
   parameter logic [K-1:0]   G0 = CONV_G0,
   parameter logic [K-1:0]   G1 = CONV_G1
) (
   input  logic [K-2:0] sr,
   input  logic         u,
   output logic [1:0]   sym
);

   logic [K-2:0] sr_rev;
   logic [K-1:0] win;

   // sr[0] is the newest history bit; reversing it lines the window up with
   // the octal generator form (MSB taps u, LSB taps the oldest bit).
   assign sr_rev = {<<{sr}};
   assign win    = {u, sr_rev};

   // Parity of the tapped window bits for both generators.
   always_comb begin
      sym    = '0;
      sym[0] = parity(MAX_K'(win), MAX_K'(G0));
      sym[1] = parity(MAX_K'(win), MAX_K'(G1));
   end

endmodule

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2, K=7 convolutional encoder with valid/ready
// handshakes and a single registered output stage.
// Optional feature macro: CONV_ENC_TAIL_EN (appends K-1 zero tail bits per frame).
module conv_encoder_k7
   import conv_code_pkg::*;
#(
   parameter int             K  = CONV_K,
   parameter logic [K-1:0]   G0 = CONV_G0,
   parameter logic [K-1:0]   G1 = CONV_G1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_pair,
   output logic       out_last,
   output logic       busy
);

   if (K < 3 || K > MAX_K) begin : g_k_range
      $error("conv_encoder_k7: K must lie in 3..9");
   end
   if (!(G0[K-1] && G0[0] && G1[K-1] && G1[0])) begin : g_poly_check
      $error("conv_encoder_k7: G0 and G1 need both MSB and LSB set");
   end

   logic [K-2:0] sr;
   logic         u;
   logic [1:0]   sym;
   logic         out_free;

   assign out_free = !out_valid || out_ready;

`ifdef CONV_ENC_TAIL_EN
   localparam int CNT_W = $clog2(K);

   enc_state_t       state;
   logic [CNT_W-1:0] tail_cnt;

   assign in_ready = (state == RUN) && out_free;
   assign u        = (state == FLUSH) ? 1'b0 : in_bit;

   // RUN accepts data bits; FLUSH pushes K-1 zero tail steps back to state 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         tail_cnt  <= '0;
         sr        <= '0;
         out_valid <= 1'b0;
         out_pair  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         unique case (state)
            RUN: begin
               if (in_valid && out_free) begin
                  out_valid <= 1'b1;
                  out_pair  <= sym;
                  out_last  <= 1'b0;
                  sr        <= {sr[K-3:0], in_bit};
                  if (in_last) begin
                     state    <= FLUSH;
                     tail_cnt <= CNT_W'(K - 1);
                     busy     <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (out_free) begin
                  out_valid <= 1'b1;
                  out_pair  <= sym;
                  sr        <= {sr[K-3:0], 1'b0};
                  tail_cnt  <= tail_cnt - CNT_W'(1);
                  if (tail_cnt == CNT_W'(1)) begin
                     out_last <= 1'b1;
                     state    <= RUN;
                     busy     <= 1'b0;
                  end else begin
                     out_last <= 1'b0;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end
`else
   assign in_ready = out_free;
   assign u        = in_bit;
   assign busy     = 1'b0;

   // Unterminated frames: last symbol is flagged and history restarts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= '0;
         out_valid <= 1'b0;
         out_pair  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (in_valid && out_free) begin
            out_valid <= 1'b1;
            out_pair  <= sym;
            out_last  <= in_last;
            if (in_last) begin
               sr <= '0;
            end else begin
               sr <= {sr[K-3:0], in_bit};
            end
         end
      end
   end
`endif

   conv_enc_symbol #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) u_symbol (
      .sr  (sr),
      .u   (u),
      .sym (sym)
   );

endmodule

// File: tb/tb_conv_encoder_k7.sv
// tb_conv_encoder_k7: randomized and directed bench for conv_encoder_k7 with a
// behavioural model (integer window, popcount parity, symbol queue).
// Follows the CONV_ENC_TAIL_EN build setting.
`timescale 1ns/1ps
module tb_conv_encoder_k7;

   localparam int KB = 7;
`ifdef CONV_ENC_TAIL_EN
   localparam int TAILN = KB - 1;
`else
   localparam int TAILN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_pair;
   logic       out_last;
   logic       busy;

   int total = 0;
   int bad = 0;
   int rdy_mode = 0;

   always #5 clk = ~clk;

   conv_encoder_k7 #(.K(7), .G0(7'o171), .G1(7'o133)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pair  (out_pair),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // window: bit6 = current input, bit(6-k) = bit accepted k steps earlier
   function automatic logic [1:0] model_sym(input int unsigned win);
      logic [1:0] s;
      s[0] = ($countones(win & 32'o171) % 2) == 1;
      s[1] = ($countones(win & 32'o133) % 2) == 1;
      return s;
   endfunction

   // ---------------- behavioural model and compare ----------------
   int unsigned hist = 0;
   int          pend = 0;
   logic        m_ov = 1'b0;
   logic        m_last = 1'b0;
   logic [1:0]  m_pair = '0;
   logic [2:0]  tail_q[$];
   logic [1:0]  got_pair[$];
   logic        got_last[$];
   int          acc_log[$];
   int          lasths_log[$];
   int          cyc = 0;
   int          busy_cnt = 0;
   logic        cons, acc, ld;
   logic [2:0]  nxt;
   int unsigned win;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         hist = 0; pend = 0; m_ov = 1'b0; m_last = 1'b0; m_pair = '0;
         tail_q.delete();
      end else begin
         chk("out_valid", out_valid, m_ov);
         chk("in_ready", in_ready, (pend == 0 && (!m_ov || out_ready)) ? 1 : 0);
         chk("busy", busy, (pend > 0) ? 1 : 0);
         if (m_ov) begin
            chk("out_pair", out_pair, m_pair);
            chk("out_last", out_last, m_last);
         end
         if (busy) busy_cnt++;
         cons = m_ov && out_ready;
         if (cons) begin
            got_pair.push_back(out_pair);
            got_last.push_back(out_last);
            if (m_last) lasths_log.push_back(cyc);
         end
         acc = in_valid && pend == 0 && (!m_ov || out_ready);
         ld = 1'b0;
         nxt = '0;
         if (pend > 0 && (!m_ov || out_ready)) begin
            nxt = tail_q.pop_front();
            pend--;
            ld = 1'b1;
         end else if (acc) begin
            acc_log.push_back(cyc);
            win = (in_bit ? 64 : 0) | (hist >> 1);
            hist = win;
            nxt = {1'b0, model_sym(win)};
`ifdef CONV_ENC_TAIL_EN
            if (in_last) begin
               for (int i = 1; i < KB; i++) begin
                  win = hist >> 1;
                  hist = win;
                  tail_q.push_back({(i == KB - 1), model_sym(win)});
               end
               pend = KB - 1;
            end
`else
            if (in_last) begin
               nxt[2] = 1'b1;
               hist = 0;
            end
`endif
            ld = 1'b1;
         end
         if (ld) begin
            m_ov = 1'b1;
            {m_last, m_pair} = nxt;
         end else if (cons) begin
            m_ov = 1'b0;
         end
      end
   end

   // ---------------- downstream ready pattern ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_bit(input logic b, input logic l);
      int n = 0;
      in_valid = 1'b1; in_bit = b; in_last = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin
            total++; bad++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 300 cycles");
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_bit = 1'($urandom); in_last = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_logs();
      got_pair.delete(); got_last.delete();
      acc_log.delete(); lasths_log.delete();
      busy_cnt = 0;
   endtask

   task automatic wait_syms(input int n, input string name);
      int t = 0;
      while ((got_pair.size() < n || m_ov || pend > 0) && t < 600) begin
         @(negedge clk); #1;
         t++;
      end
      chk(name, got_pair.size(), n);
      @(posedge clk); #1;
   endtask

   logic [1:0] imp_ref [7] = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3};
   logic [1:0] bp_ref  [4] = '{2'd3, 2'd1, 2'd0, 2'd1};
   int unsigned ph, pw;
   int t_wait, len, n_exp;

   initial begin
      // Pin the model against hand-computed symbols.
      ph = 0;
      for (int i = 0; i < 7; i++) begin
         pw = ((i == 0) ? 64 : 0) | (ph >> 1);
         ph = pw;
         chk("model_impulse", model_sym(pw), imp_ref[i]);
      end
      ph = 0;
      pw = 64 | (ph >> 1); ph = pw;
      chk("model_11_first", model_sym(pw), 3);
      pw = 64 | (ph >> 1); ph = pw;
      chk("model_11_second", model_sym(pw), 2);

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pair", out_pair, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

`ifdef CONV_ENC_TAIL_EN
      // Impulse response with tail.
      rdy_mode = 0; clear_logs();
      push_bit(1'b1, 1'b1);
      wait_syms(7, "impulse_count");
      for (int i = 0; i < 7 && i < got_pair.size(); i++) begin
         chk("impulse_sym", got_pair[i], imp_ref[i]);
         chk("impulse_last", got_last[i], (i == 6) ? 1 : 0);
      end
      chk("impulse_busy_cycles", busy_cnt, 6);

      // Back-to-back impulse frames.
      clear_logs();
      push_bit(1'b1, 1'b1);
      push_bit(1'b1, 1'b1);
      wait_syms(14, "b2b_count");
      chk("b2b_accepts", acc_log.size(), 2);
      chk("b2b_lasts", lasths_log.size(), 2);
      chk("b2b_b_after_a_last", (acc_log.size() == 2 && lasths_log.size() >= 1 &&
                                 acc_log[1] >= lasths_log[0]) ? 1 : 0, 1);
      for (int i = 0; i < 7 && 7 + i < got_pair.size(); i++)
         chk("b2b_b_sym", got_pair[7 + i], imp_ref[i]);

      // Reset during flush after the third tail symbol.
      clear_logs();
      push_bit(1'b1, 1'b1);
      t_wait = 0;
      while (got_pair.size() < 4 && t_wait < 100) begin
         @(negedge clk); #1; t_wait++;
      end
      chk("flushrst_pre_count", got_pair.size(), 4);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("flushrst_out_valid", out_valid, 0);
      chk("flushrst_busy", busy, 0);
      chk("flushrst_in_ready", in_ready, 1);
      chk("flushrst_no_last", lasths_log.size(), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
      push_bit(1'b1, 1'b1);
      wait_syms(7, "flushrst_impulse_count");
      for (int i = 0; i < 7 && i < got_pair.size(); i++)
         chk("flushrst_impulse_sym", got_pair[i], imp_ref[i]);
`else
      // Unterminated frames: {1,1} then {1}.
      rdy_mode = 0; clear_logs();
      push_bit(1'b1, 1'b0);
      push_bit(1'b1, 1'b1);
      wait_syms(2, "notail_11_count");
      if (got_pair.size() == 2) begin
         chk("notail_11_sym0", got_pair[0], 3);
         chk("notail_11_sym1", got_pair[1], 2);
         chk("notail_11_last0", got_last[0], 0);
         chk("notail_11_last1", got_last[1], 1);
      end
      clear_logs();
      push_bit(1'b1, 1'b1);
      wait_syms(1, "notail_1_count");
      if (got_pair.size() == 1) begin
         chk("notail_1_sym", got_pair[0], 3);
         chk("notail_1_last", got_last[0], 1);
      end

      // Reset mid-frame clears history.
      clear_logs();
      push_bit(1'b1, 1'b0);
      push_bit(1'b1, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
      push_bit(1'b1, 1'b1);
      wait_syms(1, "midrst_count");
      if (got_pair.size() == 1) chk("midrst_sym", got_pair[0], 3);
`endif

      // All-zero frame of 10 bits.
      rdy_mode = 0; clear_logs();
      for (int i = 0; i < 10; i++) push_bit(1'b0, (i == 9));
      wait_syms(10 + TAILN, "zero_count");
      for (int i = 0; i < got_pair.size(); i++) begin
         chk("zero_sym", got_pair[i], 0);
         chk("zero_last", got_last[i], (i == 10 + TAILN - 1) ? 1 : 0);
      end

      // Backpressure: out_ready toggles every cycle.
      rdy_mode = 1; clear_logs();
      push_bit(1'b1, 1'b0);
      push_bit(1'b0, 1'b0);
      push_bit(1'b1, 1'b0);
      push_bit(1'b1, 1'b1);
      wait_syms(4 + TAILN, "bp_count");
      for (int i = 0; i < 4 && i < got_pair.size(); i++)
         chk("bp_sym", got_pair[i], bp_ref[i]);

      // Randomized frames with random gaps and random backpressure.
      rdy_mode = 2; clear_logs();
      n_exp = 0;
      for (int f = 0; f < 10; f++) begin
         len = $urandom_range(1, 12);
         n_exp += len + TAILN;
         for (int b = 0; b < len; b++) begin
            idle($urandom_range(0, 2));
            push_bit(1'($urandom), (b == len - 1));
         end
      end
      wait_syms(n_exp, "random_count");
      chk("random_lasts", lasths_log.size(), 10);

      rdy_mode = 0;
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      bad++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
